fifo_pop_arbiter: RTL and testbench



---
 rtl/fifo_pop_arbiter.sv | 121 ++++++++++++
 tb/tb_fifo_pop_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pop_arbiter.sv
// Round-robin pop scheduler: grants one non-empty fifo at a time for up to BURST pops.
// Optional macro ARB_WORK_CONSERVING_EN: re-search on release so no IDLE cycle is spent between grants.
module fifo_pop_arbiter #(
    parameter int unsigned NUM_FIFOS = 4,
    parameter int unsigned BURST     = 2,
    localparam int unsigned IDX_W    = $clog2(NUM_FIFOS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] empty,
    input  logic                 ready,
    output logic [NUM_FIFOS-1:0] pop,
    output logic [IDX_W-1:0]     sel,
    output logic                 vld,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(BURST + 1);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pop_ok;
    logic [IDX_W:0]    srch_idle;
    logic [IDX_W-1:0]  rel_ptr;

    // First non-empty fifo at or after start, wrapping; MSB of result flags a hit.
    function automatic logic [IDX_W:0] search(input logic [IDX_W-1:0] start,
                                              input logic [NUM_FIFOS-1:0] emp);
        logic             found;
        logic [IDX_W-1:0] pick;
        int unsigned      idx;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NUM_FIFOS; k++) begin
            idx = 32'(start) + k;
            if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
            if (!found && !emp[IDX_W'(idx)]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
        return {found, pick};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop_ok    = (state_q == SERVE) && ready && !empty[cur_q];
    assign srch_idle = search(rr_q, empty);
    assign rel_ptr   = (cur_q == IDX_W'(NUM_FIFOS - 1)) ? '0 : cur_q + IDX_W'(1);

`ifdef ARB_WORK_CONSERVING_EN
    logic [IDX_W:0] srch_rel;
    assign srch_rel = search(rel_ptr, empty);
`endif

    // Next-state: grant from IDLE, count pops in SERVE, release on burst end or drain.
    always_comb begin
        logic release_now;
        state_d     = state_q;
        rr_d        = rr_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (srch_idle[IDX_W]) begin
                    cur_d   = srch_idle[IDX_W-1:0];
                    cnt_d   = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (pop_ok) begin
                    if (cnt_q == CNT_W'(BURST - 1)) release_now = 1'b1;
                    else                             cnt_d = cnt_q + CNT_W'(1);
                end else if (empty[cur_q]) begin
                    release_now = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (release_now) begin
            rr_d    = rel_ptr;
            cnt_d   = '0;
            state_d = IDLE;
`ifdef ARB_WORK_CONSERVING_EN
            if (srch_rel[IDX_W]) begin
                cur_d   = srch_rel[IDX_W-1:0];
                state_d = SERVE;
            end
`endif
        end
    end

    // Outputs follow registered state directly so a reset clears pop immediately.
    always_comb begin
        pop         = '0;
        pop[cur_q]  = pop_ok;
    end

    assign vld  = pop_ok;
    assign sel  = cur_q;
    assign busy = (state_q == SERVE);

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Self-checking bench for fifo_pop_arbiter: word-count fifo model, per-cycle compare, directed and random phases.
// Honors ARB_WORK_CONSERVING_EN for expected rotation timing.
module tb_fifo_pop_arbiter;

    localparam int N = 4;
    localparam int B = 2;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  empty;
    logic          ready;
    logic [N-1:0]  pop;
    logic [IW-1:0] sel;
    logic          vld;
    logic          busy;

    fifo_pop_arbiter #(.NUM_FIFOS(N), .BURST(B)) dut (
        .clk(clk), .rst(rst), .empty(empty), .ready(ready),
        .pop(pop), .sel(sel), .vld(vld), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: words held per fifo plus the current grant.
    int wc[N];
    bit m_serv;
    int m_cur, m_cnt, m_rr;

    // Samples of the DUT outputs taken in the latest step
    int s_pop, s_sel, s_busy, s_idx;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic int search(input int start, input logic [N-1:0] e);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (!e[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] p);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (p[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    task automatic model_reset();
        m_serv = 0; m_cur = 0; m_cnt = 0; m_rr = 0;
    endtask

    task automatic model_release(input logic [N-1:0] e);
        m_rr   = (m_cur + 1) % N;
        m_cnt  = 0;
        m_serv = 0;
`ifdef ARB_WORK_CONSERVING_EN
        begin
            int s;
            s = search(m_rr, e);
            if (s >= 0) begin m_serv = 1; m_cur = s; end
        end
`endif
    endtask

    task automatic model_edge(input logic [N-1:0] e, input bit rdy);
        if (!m_serv) begin
            int s;
            s = search(m_rr, e);
            if (s >= 0) begin m_serv = 1; m_cur = s; m_cnt = 0; end
        end else if (rdy && !e[m_cur]) begin
            wc[m_cur]--;
            if (m_cnt == B - 1) model_release(e);
            else m_cnt++;
        end else if (e[m_cur]) begin
            model_release(e);
        end
    endtask

    // One clock: drive at negedge, compare against the model, advance model at posedge.
    task automatic step(input bit r, input bit rdy, input bit pulse);
        logic [N-1:0] e;
        int exp_pop;
        @(negedge clk);
        rst   = r;
        ready = rdy;
        for (int i = 0; i < N; i++) e[i] = (wc[i] == 0);
        empty = e;
        if (r) model_reset();
        #1;
        exp_pop = (m_serv && rdy && !e[m_cur]) ? (1 << m_cur) : 0;
        chk("pop",  int'(pop),  exp_pop);
        chk("vld",  int'(vld),  int'(exp_pop != 0));
        chk("sel",  int'(sel),  m_cur);
        chk("busy", int'(busy), int'(m_serv));
        s_pop = int'(pop); s_sel = int'(sel); s_busy = int'(busy);
        s_idx = onehot_idx(pop);
        if (pulse) begin
            #1 rst = 1'b1;
            #1;
            chk("async_rst_pop",  int'(pop),  0);
            chk("async_rst_busy", int'(busy), 0);
            chk("async_rst_sel",  int'(sel),  0);
            model_reset();
            #1 rst = 1'b0;
        end
        @(posedge clk);
        if (!rst) model_edge(e, rdy);
    endtask

    task automatic clear_words();
        for (int i = 0; i < N; i++) wc[i] = 0;
    endtask

`ifdef ARB_WORK_CONSERVING_EN
    int rot_exp[] = '{-1, 0, 0, 1, 1, 2, 2, 3, 3, 0};
`else
    int rot_exp[] = '{-1, 0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0};
`endif

    initial begin
        int got[$];
        int budget;
        rst = 1'b1; ready = 1'b0; empty = '1;
        clear_words();
        model_reset();

        // Reset with all fifos full and ready high: nothing may pop
        for (int i = 0; i < N; i++) wc[i] = 100;
        repeat (2) begin
            step(1, 1, 0);
            chk("rst_pop", s_pop, 0);
            chk("rst_busy", s_busy, 0);
            chk("rst_sel", s_sel, 0);
        end

        // Full rotation
        foreach (rot_exp[k]) begin
            step(0, 1, 0);
            chk($sformatf("rotation[%0d]", k), s_idx, rot_exp[k]);
        end

        // Early drain: fifo 2 holds one word
        clear_words();
        step(1, 1, 0);
        wc[2] = 1;
        step(0, 1, 0); chk("drain_idle_busy", s_busy, 0);
        step(0, 1, 0); chk("drain_pop", s_pop, 4); chk("drain_sel", s_sel, 2);
        step(0, 1, 0); chk("drain_release_pop", s_pop, 0); chk("drain_release_busy", s_busy, 1);
        step(0, 1, 0); chk("drain_busy_fall", s_busy, 0);

        // Wrap and skip from rr_ptr=3 with fifos 1 and 3 non-empty
        wc[1] = 1; wc[3] = 1;
        got.delete();
        budget = 8;
        while (got.size() < 2 && budget > 0) begin
            step(0, 1, 0);
            if (s_idx >= 0) got.push_back(s_idx);
            budget--;
        end
        chk("wrap_pops_seen", got.size(), 2);
        if (got.size() == 2) begin
            chk("wrap_first", got[0], 3);
            chk("wrap_second", got[1], 1);
        end

        // Backpressure in SERVE on fifo 1 with one pop done
        clear_words();
        step(1, 1, 0);
        wc[1] = 10;
        step(0, 1, 0);
        step(0, 1, 0); chk("bp_first_pop", s_pop, 2);
        repeat (5) begin
            step(0, 0, 0);
            chk("bp_hold_pop", s_pop, 0);
            chk("bp_hold_sel", s_sel, 1);
            chk("bp_hold_busy", s_busy, 1);
        end
        step(0, 1, 0); chk("bp_resume_pop", s_pop, 2);
        step(0, 1, 0);
`ifdef ARB_WORK_CONSERVING_EN
        chk("bp_after_busy", s_busy, 1); chk("bp_after_pop", s_pop, 2);
`else
        chk("bp_after_busy", s_busy, 0); chk("bp_after_pop", s_pop, 0);
`endif

        // Async reset pulsed mid-burst while pop[1] is high
        clear_words();
        step(1, 1, 0);
        wc[1] = 10;
        step(0, 1, 0);
        step(0, 1, 1); chk("mid_pop_before", s_pop, 2);
        step(0, 1, 0); chk("post_rst_busy", s_busy, 1); chk("post_rst_pop", s_pop, 2);

        // Random traffic, readiness and occasional resets
        clear_words();
        step(1, 1, 0);
        for (int c = 0; c < 3000; c++) begin
            bit r, rdy, pl;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0 && wc[i] < 20) wc[i] += $urandom_range(1, 4);
            r   = ($urandom_range(0, 199) == 0);
            pl  = !r && ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(r, rdy, pl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
